// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver: snapshots all digit patterns at
// frame start, then lights one digit per slot with a dark gap at the start of each slot.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    frame_done
);

    // state | meaning
    // IDLE  | parked dark, waiting for en
    // BLANK | slot start, all anodes off while cathodes settle
    // SHOW  | digit idx driven from the frame snapshot

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   cnt, cnt_nxt;
    logic [IW-1:0]                   idx, idx_nxt;
    logic [NUM_DIGITS-1:0][6:0]      snap_seg;
    logic [NUM_DIGITS-1:0]           snap_mask;
    logic                            snap_take;
    logic [NUM_DIGITS-1:0]           an_d;
    logic [6:0]                      seg_d;
    logic                            frame_done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            snap_seg   <= '0;
            snap_mask  <= '0;
            an_n       <= '1;
            seg_n      <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            if (snap_take) begin
                snap_seg  <= seg_in;
                snap_mask <= blank_mask;
            end
            an_n       <= an_d;
            seg_n      <= seg_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        snap_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_nxt = S_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    snap_take = 1'b1;
                end
            end
            S_BLANK: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_BLANK_LAST) begin
                    state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (cnt == CNT_SLOT_LAST) begin
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        if (en) begin
                            state_nxt = S_BLANK;
                            snap_take = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = S_BLANK;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        an_d         = '1;
        seg_d        = 7'h7F;
        frame_done_d = 1'b0;
        if (state_nxt == S_SHOW) begin
            if (!snap_mask[idx_nxt]) begin
                an_d[idx_nxt] = 1'b0;
                seg_d         = ~snap_seg[idx_nxt];
            end
            frame_done_d = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_SLOT_LAST);
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame-position reference model compared every cycle,
// plus directed literal checks for scan order, snapshots, masking, en drop and reset.
module tb_seg_scan_driver;
    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7*ND-1:0] seg_in;
    logic [ND-1:0] blank_mask;
    logic [ND-1:0] an_n;
    logic [6:0]    seg_n;
    logic          frame_done;

    int checks   = 0;
    int failures = 0;

    seg_scan_driver #(.NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .seg_in(seg_in), .blank_mask(blank_mask),
        .an_n(an_n), .seg_n(seg_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a frame is just a position 0..FRAME-1; digit = pos/SLOT, lit after BLANK cycles.
    logic            m_active = 1'b0;
    int              m_t = 0;
    logic [7*ND-1:0] m_seg = '0;
    logic [ND-1:0]   m_mask = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (en) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_seg    <= seg_in;
                m_mask   <= blank_mask;
            end
        end else if (m_t == FRAME - 1) begin
            if (en) begin
                m_t    <= 0;
                m_seg  <= seg_in;
                m_mask <= blank_mask;
            end else begin
                m_active <= 1'b0;
            end
        end else begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        logic [ND-1:0] e_an;
        logic [6:0]    e_seg;
        logic          e_fd;
        int            d;
        e_an  = '1;
        e_seg = 7'h7F;
        e_fd  = 1'b0;
        if (m_active) begin
            d = m_t / SLOT;
            if ((m_t % SLOT) >= BLANK && !m_mask[d]) begin
                e_an[d] = 1'b0;
                e_seg   = ~m_seg[7*d +: 7];
            end
            e_fd = (m_t == FRAME - 1);
        end
        chk("model_an_n", 32'(an_n), 32'(e_an));
        chk("model_seg_n", 32'(seg_n), 32'(e_seg));
        chk("model_frame_done", 32'(frame_done), 32'(e_fd));
    end

    task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s, input logic f);
        chk({name, "_an_n"}, 32'(an_n), 32'(a));
        chk({name, "_seg_n"}, 32'(seg_n), 32'(s));
        chk({name, "_frame_done"}, 32'(frame_done), 32'(f));
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        seg_in     = {7'h06, 7'h5B, 7'h4F, 7'h66};
        blank_mask = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lit("reset", 4'hF, 7'h7F, 1'b0);
        end
        rst_n = 1'b1;

        for (int n = 0; n <= 144; n++) begin
            @(negedge clk);
            case (n)
                0, 1:    lit("first_blank", 4'hF, 7'h7F, 1'b0);
                2, 7:    lit("digit0", 4'hE, 7'h19, 1'b0);
                8:       lit("gap01", 4'hF, 7'h7F, 1'b0);
                10:      lit("digit1", 4'hD, 7'h30, 1'b0);
                18:      lit("digit2", 4'hB, 7'h24, 1'b0);
                26:      lit("digit3", 4'h7, 7'h79, 1'b0);
                30:      lit("pre_done", 4'h7, 7'h79, 1'b0);
                31:      lit("frame_done", 4'h7, 7'h79, 1'b1);
                32:      lit("frame1_blank", 4'hF, 7'h7F, 1'b0);
                34:      lit("new_snapshot", 4'hE, 7'h40, 1'b0);
                82:      lit("mask_digit2", 4'hB, 7'h24, 1'b0);
                90:      lit("mask_digit3", 4'hF, 7'h7F, 1'b0);
                95:      lit("mask_done", 4'hF, 7'h7F, 1'b1);
                114:     lit("endrop_digit2", 4'hB, 7'h24, 1'b0);
                127:     lit("endrop_done", 4'hF, 7'h7F, 1'b1);
                128,135: lit("idle_dark", 4'hF, 7'h7F, 1'b0);
                141:     lit("reset_mid_show", 4'hF, 7'h7F, 1'b0);
                142,143: lit("restart_blank", 4'hF, 7'h7F, 1'b0);
                144:     lit("restart_digit0", 4'hE, 7'h40, 1'b0);
                default: ;
            endcase
            case (n)
                16:  seg_in[6:0] = 7'h3F;
                40:  blank_mask  = 4'b1000;
                106: en          = 1'b0;
                135: en          = 1'b1;
                140: rst_n       = 1'b0;
                141: rst_n       = 1'b1;
                default: ;
            endcase
        end

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            en    = ($urandom_range(15) != 0);
            rst_n = ($urandom_range(299) != 0);
            if ($urandom_range(5) == 0) seg_in = 28'($urandom);
            if ($urandom_range(9) == 0) blank_mask = 4'($urandom);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
